// File: rtl/key_addr_sched_if.sv
// Requester, hash-unit and response signals of the key-address scheduler.
// The scheduler connects through the master modport; the environment through slave.
interface key_addr_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned ADDR_W = 20;

  logic [NUM_REQ-1:0]       req_valid;
  logic [KEY_W*NUM_REQ-1:0] req_key;
  logic [NUM_REQ-1:0]       req_ready;

  logic                     hash_req;
  logic [KEY_W-1:0]         hash_key;
  logic [ADDR_W-1:0]        hash_addr;
  logic                     hash_addr_valid;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [ADDR_W-1:0]        rsp_addr;
  logic                     rsp_err;

  modport master (
    input  req_valid, req_key, hash_addr, hash_addr_valid, rsp_ready,
    output req_ready, hash_req, hash_key, rsp_valid, rsp_id, rsp_addr, rsp_err
  );

  modport slave (
    output req_valid, req_key, hash_addr, hash_addr_valid, rsp_ready,
    input  req_ready, hash_req, hash_key, rsp_valid, rsp_id, rsp_addr, rsp_err
  );
endinterface

// File: rtl/key_addr_sched.sv
// Round-robin scheduler sharing one key-address hash unit between NUM_REQ requesters.
// One job in flight: grant a key, pulse the hash unit, wait for the address or time out, respond.
module key_addr_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  key_addr_sched_if.master  bus,
  output logic              busy,
  output logic [15:0]       job_cnt
);
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned JOB_W  = 16;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam int unsigned RV_W   = 2 ** ID_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               hash_req_q, hash_req_d;
  logic [KEY_W-1:0]   hash_key_q, hash_key_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic [JOB_W-1:0]   job_cnt_q, job_cnt_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [RV_W-1:0]    req_valid_ext;
  logic [KEY_W-1:0]   key_arr [RV_W];
  logic               gnt_vld_c;
  logic [ID_W-1:0]    gnt_idx_c;
  logic [ID_W-1:0]    gnt_cand_c;
  logic [RV_W-1:0]    gnt_oh_c;
  logic               tmo_hit_c;
  logic               rsp_hs_c;

  // Pad requests/keys to a power-of-two table so an ID_W-bit index is always in range.
  assign req_valid_ext = RV_W'(bus.req_valid);

  for (genvar g = 0; g < RV_W; g++) begin : g_key
    if (g < NUM_REQ) begin : g_real
      assign key_arr[g] = bus.req_key[KEY_W*g +: KEY_W];
    end else begin : g_pad
      assign key_arr[g] = '0;
    end
  end

  // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_vld_c  = 1'b0;
    gnt_idx_c  = '0;
    gnt_cand_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_cand_c = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_vld_c && req_valid_ext[gnt_cand_c]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = gnt_cand_c;
      end
    end
  end

  always_comb begin
    gnt_oh_c            = '0;
    gnt_oh_c[gnt_idx_c] = 1'b1;
  end

  // The valid strobe takes priority over the final timeout cycle.
  assign tmo_hit_c = (tmo_cnt_q == CNT_W'(TIMEOUT - 2));
  assign rsp_hs_c  = rsp_valid_q & bus.rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt_vld_c) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.hash_addr_valid || tmo_hit_c) state_d = S_RESP;
      S_RESP:  if (rsp_hs_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = '0;
    hash_req_d  = 1'b0;
    hash_key_d  = hash_key_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    job_cnt_d   = job_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    tmo_cnt_d   = tmo_cnt_q;
    busy_d      = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld_c) begin
          req_ready_d = gnt_oh_c[NUM_REQ-1:0];
          hash_req_d  = 1'b1;
          hash_key_d  = key_arr[gnt_idx_c];
          rsp_id_d    = gnt_idx_c;
          rr_ptr_d    = ID_W'((32'(gnt_idx_c) + 32'd1) % NUM_REQ);
        end
      end
      S_ISSUE: tmo_cnt_d = '0;
      S_WAIT: begin
        if (bus.hash_addr_valid) begin
          rsp_addr_d  = bus.hash_addr;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (tmo_hit_c) begin
          rsp_addr_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_hs_c) begin
          rsp_valid_d = 1'b0;
          job_cnt_d   = job_cnt_q + JOB_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_q <= '0;
      hash_req_q  <= 1'b0;
      hash_key_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      job_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      hash_req_q  <= hash_req_d;
      hash_key_q  <= hash_key_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      job_cnt_q   <= job_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.hash_req  = hash_req_q;
  assign bus.hash_key  = hash_key_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;
  assign job_cnt       = job_cnt_q;
endmodule

// File: tb/tb_key_addr_sched.sv
// Scoreboard bench for key_addr_sched: a bench-side round-robin model predicts each grant
// and response; a latency-programmable hash model answers hash_req.
`timescale 1ns/1ps
module tb_key_addr_sched;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [19:0]     addr;
    logic            err;
    int              lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] job_cnt;

  key_addr_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bif ();

  key_addr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .bus     (bif.master),
    .busy    (busy),
    .job_cnt (job_cnt)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  exp_t         sb_q[$];
  logic [127:0] key_q[$];
  logic [3:0]   rv_snap;
  logic [127:0] ks_snap [NUM_REQ];
  int           rem [NUM_REQ];
  int           resp_by_id [NUM_REQ];
  int           rr_m = 0;
  int           jobs_m = 0;
  int           hash_lat = 2;
  int           cd = 0;
  logic [127:0] hk_m = '0;
  int           issue_cyc = 0;
  int           hs_cyc = 0;
  logic         rsp_open = 1'b0;
  logic         chk_turn = 1'b0;
  exp_t         cur_exp;
  int           n_gnt = 0;
  int           n_hreq = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [19:0] hash_fn(input logic [127:0] k);
    return k[35:16] ^ k[127:108];
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // Bench copy of what the DUT samples on each rising edge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rv_snap <= bif.req_valid;
    for (int i = 0; i < NUM_REQ; i++) ks_snap[i] <= bif.req_key[128*i +: 128];
  end

  // Hash unit: answers hash_lat cycles after hash_req; hash_lat = 0 never answers.
  always @(negedge clk) begin
    bif.hash_addr_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bif.hash_addr_valid = 1'b1;
        bif.hash_addr       = hash_fn(hk_m);
      end
    end
    if (rst_n === 1'b1 && bif.hash_req === 1'b1 && hash_lat > 0) begin
      cd   = hash_lat;
      hk_m = bif.hash_key;
    end
  end

  task automatic monitor();
    int         g;
    logic [3:0] oh;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bif.req_ready != '0) begin
          g  = rr_pick(rv_snap, rr_m);
          oh = '0;
          if (g >= 0) oh[g] = 1'b1;
          chk("req_ready", 128'(bif.req_ready), 128'(oh));
          if (chk_turn) begin
            chk("turnaround", 128'(cyc - hs_cyc), 128'(2));
            chk_turn = 1'b0;
          end
          n_gnt++;
          if (g >= 0) begin
            e.id   = ID_W'(g);
            e.err  = (hash_lat == 0 || hash_lat > int'(TIMEOUT) - 1);
            e.addr = e.err ? 20'h0 : hash_fn(ks_snap[g]);
            e.lat  = e.err ? int'(TIMEOUT) : hash_lat + 1;
            sb_q.push_back(e);
            key_q.push_back(ks_snap[g]);
            rr_m = (g + 1) % NUM_REQ;
            rem[g]--;
            if (rem[g] > 0) bif.req_key[128*g +: 128] = rand_key();
            else            bif.req_valid[g] = 1'b0;
          end
        end
        if (bif.hash_req) begin
          n_hreq++;
          issue_cyc = cyc;
          if (key_q.size() > 0) chk("hash_key", bif.hash_key, key_q.pop_front());
          else                  chk("hash_req_spurious", 128'(1), 128'(0));
        end
        if (bif.rsp_valid) begin
          chk("busy_in_resp", 128'(busy), 128'(1));
          chk("req_ready_in_resp", 128'(bif.req_ready), 128'(0));
          chk("hash_req_in_resp", 128'(bif.hash_req), 128'(0));
          if (!rsp_open) begin
            rsp_open = 1'b1;
            if (sb_q.size() == 0) chk("rsp_spurious", 128'(1), 128'(0));
            else begin
              cur_exp = sb_q.pop_front();
              chk("rsp_latency", 128'(cyc - issue_cyc), 128'(cur_exp.lat));
            end
          end
          chk("rsp_id", 128'(bif.rsp_id), 128'(cur_exp.id));
          chk("rsp_addr", 128'(bif.rsp_addr), 128'(cur_exp.addr));
          chk("rsp_err", 128'(bif.rsp_err), 128'(cur_exp.err));
          if (bif.rsp_ready) begin
            chk("job_cnt", 128'(job_cnt), 128'(jobs_m));
            jobs_m++;
            resp_by_id[bif.rsp_id]++;
            rsp_open = 1'b0;
            hs_cyc   = cyc;
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic post(input int r, input int n, input logic [127:0] k);
    rem[r]                    = n;
    bif.req_key[128*r +: 128] = k;
    bif.req_valid[r]          = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (t < budget && !(sb_q.size() == 0 && !busy && bif.req_valid == '0 && !bif.rsp_valid)) begin
      tick(1);
      t++;
    end
    chk("idle_wait_expired", 128'(t >= budget), 128'(0));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 128'(bif.req_ready), 128'(0));
    chk("rst_hash_req", 128'(bif.hash_req), 128'(0));
    chk("rst_hash_key", bif.hash_key, 128'(0));
    chk("rst_rsp_valid", 128'(bif.rsp_valid), 128'(0));
    chk("rst_rsp_id", 128'(bif.rsp_id), 128'(0));
    chk("rst_rsp_addr", 128'(bif.rsp_addr), 128'(0));
    chk("rst_rsp_err", 128'(bif.rsp_err), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_job_cnt", 128'(job_cnt), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lats [4];
    int t;
    lats = '{18, 1, 3, 16};
    rst_n         = 1'b0;
    bif.req_valid = '0;
    bif.req_key   = '0;
    bif.rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i]        = 0;
      resp_by_id[i] = 0;
    end
    #3;
    chk_reset_outputs();
    tick(3);
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    tick(2);

    // Single request from requester 0.
    hash_lat = 2;
    post(0, 1, 128'h1_0000);
    wait_idle(50);
    chk("job_cnt_after_first", 128'(job_cnt), 128'(1));

    // All four requesters held busy for two jobs each.
    for (int i = 0; i < NUM_REQ; i++) resp_by_id[i] = 0;
    for (int i = 0; i < NUM_REQ; i++) post(i, 2, rand_key());
    wait_idle(200);
    for (int i = 0; i < NUM_REQ; i++) chk($sformatf("rr_share_%0d", i), 128'(resp_by_id[i]), 128'(2));

    // Back-pressure with requester 2 waiting.
    bif.rsp_ready = 1'b0;
    post(0, 1, rand_key());
    t = 0;
    while (!bif.rsp_valid && t < 50) begin
      tick(1);
      t++;
    end
    chk("bp_rsp_seen", 128'(bif.rsp_valid), 128'(1));
    post(2, 1, rand_key());
    tick(10);
    chk("bp_no_grant", 128'(bif.req_valid[2]), 128'(1));
    chk_turn      = 1'b1;
    bif.rsp_ready = 1'b1;
    wait_idle(100);
    chk("bp_turn_seen", 128'(chk_turn), 128'(0));

    // Latency sweep including timeout, late stale strobe and the timeout boundary.
    for (int i = 0; i < 4; i++) begin
      hash_lat = lats[i];
      post(1, 1, rand_key());
      wait_idle(100);
      tick(5);
    end

    // Valid on the last WAIT cycle wins over the timeout.
    hash_lat = int'(TIMEOUT) - 1;
    post(3, 1, rand_key());
    wait_idle(100);
    hash_lat = 2;
    post(3, 1, rand_key());
    wait_idle(50);

    // Reset in WAIT: job dropped, rr pointer back to 0.
    hash_lat = 0;
    post(2, 1, rand_key());
    t = 0;
    while (!busy && t < 20) begin
      tick(1);
      t++;
    end
    tick(4);
    chk("rst_in_wait_busy", 128'(busy), 128'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    sb_q.delete();
    key_q.delete();
    rr_m     = 0;
    jobs_m   = 0;
    rsp_open = 1'b0;
    hash_lat = 2;
    post(3, 1, rand_key());
    post(1, 1, rand_key());
    tick(3);
    rst_n = 1'b1;
    wait_idle(100);
    chk("rst_jobs_after", 128'(job_cnt), 128'(2));

    chk("final_job_cnt", 128'(job_cnt), 128'(jobs_m));
    chk("grants_vs_hash_reqs", 128'(n_hreq), 128'(n_gnt));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
